// File: rtl/xeng_window_sched_pkg.sv
// Shared definitions for the X-engine window scheduler: FSM encoding and
// the address-width / window-length derivations.
package xeng_window_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } sched_state_t;

   localparam int UNDERRUN_W = 16;
   localparam int N_BUFS     = 2;

   // Read address is {sample_idx, ant_idx}.
   function automatic int addr_w(input int n_ants, input int sal_bits);
      return $clog2(n_ants) + sal_bits;
   endfunction

   function automatic int win_len(input int n_ants, input int sal_bits);
      return n_ants << sal_bits;
   endfunction

endpackage

// File: rtl/xeng_window_sched_delay.sv
// Resettable LATENCY-deep register pipeline that lines the scheduler's
// control/timestamp word up with the buffer read data.
module xeng_sched_delay #(
   parameter int LATENCY = 2,
   parameter int WIDTH   = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   genvar gi;
   generate
      if (LATENCY == 0) begin : g_bypass
         assign dout = din;
      end else begin : g_pipe
         for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_reg;
            if (gi == 0) begin : g_first
               always_ff @(posedge clk) begin
                  if (rst) stage_reg <= '0;
                  else     stage_reg <= din;
               end
            end else begin : g_next
               always_ff @(posedge clk) begin
                  if (rst) stage_reg <= '0;
                  else     stage_reg <= g_stage[gi-1].stage_reg;
               end
            end
         end
         assign dout = g_stage[LATENCY-1].stage_reg;
      end
   endgenerate

endmodule

// File: rtl/xeng_window_sched.sv
// Ping-pong buffer read scheduler for the X-engine: emits back-to-back read
// windows, tracks buffer occupancy and produces aligned sync/valid/mcnt.
module xeng_window_sched
   import xeng_window_sched_pkg::*;
#(
   parameter int N_ANTS              = 64,
   parameter int SERIAL_ACC_LEN_BITS = 7,
   parameter int MCNT_WIDTH          = 48,
   parameter int BRAM_LATENCY        = 2,
   localparam int ADDR_W             = addr_w(N_ANTS, SERIAL_ACC_LEN_BITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [1:0]            buf_fill,
   input  logic [MCNT_WIDTH-1:0] fill_mcnt,
   output logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_sel,
   output logic [1:0]            buf_free,
   output logic                  sync_out,
   output logic                  vld_out,
   output logic [MCNT_WIDTH-1:0] mcnt_out,
   output logic [15:0]           underrun_cnt,
   output logic                  overflow
);

   localparam int WIN_LEN = win_len(N_ANTS, SERIAL_ACC_LEN_BITS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIN_LEN - 1);
   localparam int PIPE_W = MCNT_WIDTH + 2;

   sched_state_t            state_reg;
   logic [ADDR_W-1:0]       cnt_reg;
   logic                    cur_reg;
   logic                    win_vld_reg;
   logic [UNDERRUN_W-1:0]   underrun_reg;
   logic                    overflow_reg;
   logic [N_BUFS-1:0]       full_reg;
   logic [MCNT_WIDTH-1:0]   mcnt_reg [N_BUFS];
   logic [MCNT_WIDTH-1:0]   mcnt_last_reg;

   logic                    win_end;
   logic                    end_valid;
   logic                    cur_next;
   logic [N_BUFS-1:0]       clear;
   logic [N_BUFS-1:0]       full_next;
   logic [N_BUFS-1:0]       ovf_hit;
   logic                    raw_sync;
   logic                    raw_vld;
   logic [MCNT_WIDTH-1:0]   raw_mcnt;
   logic [PIPE_W-1:0]       pipe_out;

   assign win_end   = (state_reg == ST_RUN) && (cnt_reg == LAST_ADDR);
   assign end_valid = win_end && win_vld_reg;
   assign cur_next  = cur_reg ^ end_valid;

   // A fill landing on the same cycle as the consume-clear wins: the buffer
   // was legitimately refilled, so it is neither freed nor an overflow.
   genvar gi;
   generate
      for (gi = 0; gi < N_BUFS; gi++) begin : g_buf
         assign clear[gi]     = end_valid && (cur_reg == 1'(gi));
         assign full_next[gi] = buf_fill[gi] | (full_reg[gi] & ~clear[gi]);
         assign ovf_hit[gi]   = buf_fill[gi] & full_reg[gi] & ~clear[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         full_reg      <= '0;
         overflow_reg  <= 1'b0;
         for (int b = 0; b < N_BUFS; b++) mcnt_reg[b] <= '0;
      end else begin
         full_reg <= full_next;
         if (|ovf_hit) overflow_reg <= 1'b1;
         for (int b = 0; b < N_BUFS; b++) begin
            if (buf_fill[b]) mcnt_reg[b] <= fill_mcnt;
         end
      end
   end

   // Window validity is registered one cycle early from next-state occupancy,
   // which equals sampling full[cur] on the window's first cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         cur_reg      <= 1'b0;
         win_vld_reg  <= 1'b0;
         underrun_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               cnt_reg     <= '0;
               win_vld_reg <= 1'b0;
               if (en) state_reg <= ST_SYNC;
            end
            ST_SYNC: begin
               state_reg   <= ST_RUN;
               cnt_reg     <= '0;
               win_vld_reg <= full_next[cur_reg];
            end
            ST_RUN: begin
               if (win_end) begin
                  cnt_reg <= '0;
                  cur_reg <= cur_next;
                  if (!win_vld_reg && (underrun_reg != {UNDERRUN_W{1'b1}}))
                     underrun_reg <= underrun_reg + 1'b1;
                  if (en) begin
                     win_vld_reg <= full_next[cur_next];
                  end else begin
                     state_reg   <= ST_IDLE;
                     win_vld_reg <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               cnt_reg     <= '0;
               win_vld_reg <= 1'b0;
            end
         endcase
      end
   end

   assign raw_sync = (state_reg == ST_SYNC);
   assign raw_vld  = (state_reg == ST_RUN) && win_vld_reg;
   assign raw_mcnt = raw_vld ? mcnt_reg[cur_reg] : mcnt_last_reg;

   always_ff @(posedge clk) begin
      if (rst) mcnt_last_reg <= '0;
      else     mcnt_last_reg <= raw_mcnt;
   end

   xeng_sched_delay #(
      .LATENCY (BRAM_LATENCY),
      .WIDTH   (PIPE_W)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({raw_sync, raw_vld, raw_mcnt}),
      .dout (pipe_out)
   );

   assign sync_out     = pipe_out[PIPE_W-1];
   assign vld_out      = pipe_out[PIPE_W-2];
   assign mcnt_out     = pipe_out[MCNT_WIDTH-1:0];
   assign rd_addr      = cnt_reg;
   assign rd_sel       = cur_reg;
   assign buf_free     = clear;
   assign underrun_cnt = underrun_reg;
   assign overflow     = overflow_reg;

endmodule

// File: tb/tb_xeng_window_sched.sv
// Directed bench for xeng_window_sched with a 4-antenna, 16-cycle window.
module tb_xeng_window_sched;

   localparam int N_ANTS = 4;
   localparam int SAL    = 2;
   localparam int MW     = 48;
   localparam int LAT    = 2;
   localparam int AW     = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [1:0]    buf_fill;
   logic [MW-1:0] fill_mcnt;
   logic [AW-1:0] rd_addr;
   logic          rd_sel;
   logic [1:0]    buf_free;
   logic          sync_out;
   logic          vld_out;
   logic [MW-1:0] mcnt_out;
   logic [15:0]   underrun_cnt;
   logic          overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   xeng_window_sched #(
      .N_ANTS              (N_ANTS),
      .SERIAL_ACC_LEN_BITS (SAL),
      .MCNT_WIDTH          (MW),
      .BRAM_LATENCY        (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .buf_fill     (buf_fill),
      .fill_mcnt    (fill_mcnt),
      .rd_addr      (rd_addr),
      .rd_sel       (rd_sel),
      .buf_free     (buf_free),
      .sync_out     (sync_out),
      .vld_out      (vld_out),
      .mcnt_out     (mcnt_out),
      .underrun_cnt (underrun_cnt),
      .overflow     (overflow)
   );

   typedef struct {
      logic          en;
      logic [1:0]    fill;
      logic [MW-1:0] mcnt;
      logic [AW-1:0] exp_addr;
      logic          exp_sync;
      logic          exp_vld;
      logic [1:0]    exp_free;
      logic [15:0]   exp_mcnt;
   } vec_t;

   vec_t tbl [23];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end else begin
         $display("ok   %s value=0x%0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; buf_fill = 2'b00; fill_mcnt = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic fill(input int b, input logic [MW-1:0] m);
      buf_fill = (b == 0) ? 2'b01 : 2'b10;
      fill_mcnt = m;
      step();
      buf_fill = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int vcnt;
      int nfree;
      bit found;

      // ---- reset state ----
      do_reset();
      chk("reset_ctl", {rd_addr, rd_sel, buf_free, sync_out, vld_out, overflow}, '0);
      chk("reset_mcnt", mcnt_out, '0);
      chk("reset_underrun", underrun_cnt, '0);

      // ---- table: fill buffer 0, enable, one valid then one blank window ----
      tbl[0] = '{en: 1'b0, fill: 2'b01, mcnt: 48'h10, exp_addr: '0, exp_sync: 1'b0,
                 exp_vld: 1'b0, exp_free: 2'b00, exp_mcnt: 16'h0};
      for (int j = 1; j < 23; j++) begin
         k = j - 1;
         tbl[j].en       = 1'b1;
         tbl[j].fill     = 2'b00;
         tbl[j].mcnt     = '0;
         tbl[j].exp_addr = (k >= 1 && k <= 16) ? AW'(k - 1) : (k >= 17 ? AW'(k - 17) : '0);
         tbl[j].exp_sync = (k == 2);
         tbl[j].exp_vld  = (k >= 3 && k <= 18);
         tbl[j].exp_free = (k == 16) ? 2'b01 : 2'b00;
         tbl[j].exp_mcnt = (k >= 3) ? 16'h10 : 16'h0;
      end
      for (int i = 0; i < 23; i++) begin
         en = tbl[i].en; buf_fill = tbl[i].fill; fill_mcnt = tbl[i].mcnt;
         step();
         chk($sformatf("t1_row%0d", i),
             {40'h0, rd_addr, sync_out, vld_out, buf_free, mcnt_out[15:0]},
             {40'h0, tbl[i].exp_addr, tbl[i].exp_sync, tbl[i].exp_vld, tbl[i].exp_free, tbl[i].exp_mcnt});
      end
      buf_fill = 2'b00;
      repeat (12) step();
      chk("t1_underrun_after_blank", underrun_cnt, 16'd1);
      chk("t1_rdsel_toggled", rd_sel, 1'b1);

      // ---- underrun counting, then late fill becomes valid at boundary ----
      do_reset();
      en = 1'b1;
      for (k = 0; k <= 70; k++) begin
         step();
         chk($sformatf("t2_vld_k%0d", k), vld_out, (k >= 67) ? 1'b1 : 1'b0);
         if (k == 48) chk("t2_underrun_k48", underrun_cnt, 16'd2);
         if (k == 49) chk("t2_underrun_k49", underrun_cnt, 16'd3);
         if (k == 70) chk("t2_mcnt_k70", mcnt_out, 48'h44);
         buf_fill  = (k == 50) ? 2'b01 : 2'b00;
         fill_mcnt = 48'h44;
      end
      buf_fill = 2'b00;

      // ---- overflow: double fill before consumption ----
      do_reset();
      fill(0, 48'h20);
      chk("t3_no_overflow_single", overflow, 1'b0);
      fill(0, 48'h21);
      chk("t3_overflow_set", overflow, 1'b1);
      en = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         step();
         if (vld_out) found = 1'b1;
      end
      chk("t3_vld_seen", found, 1'b1);
      chk("t3_mcnt_latest", mcnt_out, 48'h21);

      // ---- ping-pong: four back-to-back valid windows ----
      do_reset();
      fill(0, 48'h50);
      fill(1, 48'h51);
      en = 1'b1; vcnt = 0; nfree = 0;
      for (k = 0; k <= 66; k++) begin
         step();
         if (k >= 3 && vld_out) vcnt++;
         if (k == 8)  chk("t4_rdsel_w1", rd_sel, 1'b0);
         if (k == 24) chk("t4_rdsel_w2", rd_sel, 1'b1);
         if (k == 40) chk("t4_rdsel_w3", rd_sel, 1'b0);
         if (k == 56) chk("t4_rdsel_w4", rd_sel, 1'b1);
         if (k == 10) chk("t4_mcnt_w1", mcnt_out, 48'h50);
         if (k == 26) chk("t4_mcnt_w2", mcnt_out, 48'h51);
         if (k == 42) chk("t4_mcnt_w3", mcnt_out, 48'h52);
         if (k == 58) chk("t4_mcnt_w4", mcnt_out, 48'h53);
         if (buf_free != 2'b00) begin
            buf_fill  = buf_free;
            fill_mcnt = 48'h52 + MW'(nfree);
            nfree++;
         end else begin
            buf_fill = 2'b00;
         end
      end
      buf_fill = 2'b00;
      chk("t4_vld_no_gap", vcnt, 64);

      // ---- reset mid-window aborts without freeing ----
      do_reset();
      en = 1'b1;
      for (k = 0; k < 18; k++) step();
      fill(0, 48'h60);
      step();
      fill(0, 48'h61);
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         step();
         if (rd_addr == 4'd7 && vld_out) found = 1'b1;
      end
      chk("t5_reached_addr7", found, 1'b1);
      chk("t5_pre_overflow", overflow, 1'b1);
      rst = 1'b1; en = 1'b0;
      step();
      chk("t5_rst_ctl", {rd_addr, rd_sel, buf_free, sync_out, vld_out, overflow}, '0);
      chk("t5_rst_mcnt", mcnt_out, '0);
      chk("t5_rst_underrun", underrun_cnt, '0);
      step();
      rst = 1'b0;
      vcnt = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (buf_free != 2'b00 || vld_out) vcnt++;
      end
      chk("t5_no_free_after_abort", vcnt, 0);

      // ---- fill coincident with free, then en drop mid-window ----
      do_reset();
      fill(0, 48'h30);
      fill(1, 48'h31);
      en = 1'b1;
      for (k = 0; k <= 55; k++) begin
         step();
         buf_fill = 2'b00;
         if (k == 16) begin
            chk("t6_free0", buf_free, 2'b01);
            buf_fill = 2'b01; fill_mcnt = 48'h32;
         end
         if (k == 17) chk("t6_no_overflow", overflow, 1'b0);
         if (k == 40) begin
            chk("t6_w3_vld_sel", {vld_out, rd_sel}, 2'b10);
            chk("t6_w3_mcnt", mcnt_out, 48'h32);
            en = 1'b0;
         end
         if (k == 48) chk("t6_finish_free", buf_free, 2'b01);
         if (k == 55) chk("t6_idle", {rd_addr, vld_out, sync_out}, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xeng_window_sched.md
XENG_WINDOW_SCHED -- requirements
Module: xeng_window_sched

Interface
REQ-001 SHALL have parameter N_ANTS, default 64, number of dual-pol antenna inputs (power of 2).
REQ-002 SHALL have parameter SERIAL_ACC_LEN_BITS, default 7, log2 of the serial accumulation length.
REQ-003 SHALL have parameter MCNT_WIDTH, default 48, timestamp width.
REQ-004 SHALL have parameter BRAM_LATENCY, default 2, read latency of the ping-pong input buffer.
REQ-005 SHALL have one clock and one reset: clk, the single clock; rst, synchronous, active-high.
REQ-006 SHALL have the following ports, one line each:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  scheduler enable
- buf_fill  input  2  one-cycle pulse per buffer: writer has finished filling buffer b
- fill_mcnt  input  MCNT_WIDTH  timestamp of the buffer being filled, sampled with buf_fill
- rd_addr  output  ADDR_W  buffer read address {sample_idx, ant_idx}, with ADDR_W = log2(N_ANTS)+SERIAL_ACC_LEN_BITS
- rd_sel  output  1  buffer being read
- buf_free  output  2  one-cycle pulse: buffer b has been consumed
- sync_out  output  1  X-engine sync pulse
- vld_out  output  1  X-engine window-valid flag
- mcnt_out  output  MCNT_WIDTH  timestamp for the X-engine
- underrun_cnt  output  16  count of blank windows
- overflow  output  1  sticky flag: a fill arrived for a buffer that was already full

Function
REQ-007 SHALL define the window length W = N_ANTS*2^SERIAL_ACC_LEN_BITS cycles, matching the X-engine mcnt sample period.
REQ-008 SHALL implement states IDLE, SYNC, RUN.
- IDLE->SYNC when en=1.
- SYNC lasts exactly 1 cycle, then ->RUN.
- RUN loops windows back-to-back with no gap cycles.
- At a window end with en=0: ->IDLE.
REQ-009 SHALL, within a window, count ant_idx fastest (0..N_ANTS-1) and sample_idx slowest; rd_addr wraps to 0 at each window start.
REQ-010 SHALL decide each window at its first cycle: if buffer cur (toggling pointer, 0 after reset) is full, the window is valid and reads buffer cur; otherwise the window is blank.
REQ-011 SHALL hold the raw vld high for every cycle of a valid window and low for every cycle of a blank window; the window counter still runs in blank windows.
REQ-012 SHALL, at the last cycle of a valid window, pulse buf_free[cur], clear full[cur] and toggle cur; a blank window changes none of these.
REQ-013 SHALL increment underrun_cnt on each blank window, saturating at 0xFFFF.
REQ-014 SHALL set full[b] on buf_fill[b] and latch fill_mcnt into mcnt_reg[b]; a fill while full[b]=1 sets overflow and overwrites mcnt_reg[b].
REQ-015 SHALL give priority to the fill when buf_fill[b] and the clear of full[b] occur in the same cycle: full[b] stays 1, and overflow is not set.
REQ-016 SHALL raise the raw sync only in the SYNC state, i.e. once per enable, 1 cycle before the first window cycle.
REQ-017 SHALL delay sync_out, vld_out and mcnt_out by BRAM_LATENCY cycles relative to rd_addr, so they align with buffer read data.
REQ-018 SHALL drive mcnt_out with mcnt_reg[cur] during valid windows and hold its last value during blank windows.
REQ-019 SHALL, when en is deasserted mid-window, finish the current window, including any buf_free pulse, before going to IDLE.
REQ-020 SHALL drive rd_sel with cur and keep rd_addr at 0 in IDLE.

Reset
REQ-021 SHALL, on rst, set state to IDLE; cur, full, mcnt_reg, counters, underrun_cnt and overflow to 0.
REQ-022 SHALL hold all outputs 0 during reset, including the contents of the output delay pipeline.
REQ-023 SHALL abort any window in progress on rst with no buf_free pulse.

Structure
REQ-024 SHALL place the state encoding and the ADDR_W/W derivation functions in the shared xeng package.
REQ-025 SHALL use one sub-module, xeng_sched_delay: a BRAM_LATENCY-deep register pipeline with reset for {sync, vld, mcnt}.

Verification (N_ANTS=4, SERIAL_ACC_LEN_BITS=2, W=16, BRAM_LATENCY=2)
REQ-026 Fill buffer 0 with mcnt=0x10, then en=1 -> sync_out pulses once; vld_out is high for 16 cycles starting 1 cycle later; mcnt_out=0x10; rd_addr runs 0..15; buf_free[0] pulses at rd_addr=15.
REQ-027 en=1 with no fills -> vld_out stays 0 and underrun_cnt reaches 3 after 48 cycles; a fill of buffer 0 then yields valid data at the next window boundary.
REQ-028 Fill buffer 0 twice before consumption with mcnt 0x20 then 0x21 -> overflow=1 and mcnt_out=0x21.
REQ-029 Alternating fills of buffers 0 and 1 ahead of consumption -> 4 consecutive valid windows with rd_sel 0,1,0,1 and no gap cycles.
REQ-030 rst asserted at rd_addr=7 -> all outputs are 0 the next cycle; no buf_free pulse occurs; overflow and underrun_cnt are 0.
REQ-031 buf_fill[0] coincident with buf_free[0] -> full[0] remains 1 and the next window is valid with the new mcnt.
